// File: rtl/ccd_seq_pkg.sv
// Shared state encoding and default sizing for the CCD row sequencer.
package ccd_seq_pkg;

    localparam int DEF_ROW_W          = 12;
    localparam int DEF_GAP_W          = 8;
    localparam int DEF_TIMEOUT_CYCLES = 64;
    // Cycles the three-phase clock generator needs to finish one row shift.
    localparam int CLK_GEN_CYCLES     = 53;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP,
        DRAIN
    } seq_state_t;

endpackage

// File: rtl/ccd_row_sequencer_if.sv
// Enable/completion link between the row sequencer and the CCD clock generator.
interface ccd_row_sequencer_if;

    logic shift_en;
    logic shift_done;

    modport master (output shift_en, input shift_done);
    modport slave  (input shift_en, output shift_done);

endinterface

// File: rtl/seq_delay_counter.sv
// Loadable down-counter that stops at zero; used for inter-row gaps and the shift watchdog.
module seq_delay_counter #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ccd_row_sequencer.sv
// Issues one clock-generator shift per CCD row with a programmable gap and counts completions.
// Optional shift watchdog and sticky timeout_err enabled by defining SHIFT_TIMEOUT_EN.
module ccd_row_sequencer
    import ccd_seq_pkg::*;
#(
    parameter int ROW_W = DEF_ROW_W,
    parameter int GAP_W = DEF_GAP_W
`ifdef SHIFT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ROW_W-1:0]    num_rows,
    input  logic [GAP_W-1:0]    gap_cycles,
    input  logic                abort,
    ccd_row_sequencer_if.master clkgen,
    output logic                busy,
    output logic [ROW_W-1:0]    row_count,
    output logic                frame_done,
    output logic                timeout_err
);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic              done_q;
    logic              done_rise;
    logic [ROW_W-1:0]  rows_q;
    logic [GAP_W-1:0]  gap_q;
    logic              accept;
    logic              count_row;
    logic              frame_done_d;
    logic              gap_load;
    logic              gap_zero;
    logic              wd_expired;

    // A completion flag that is already high is a stale level, not a new finish.
    assign done_rise = clkgen.shift_done & ~done_q;

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        count_row    = 1'b0;
        frame_done_d = 1'b0;
        gap_load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        accept  = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = abort ? DRAIN : WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    count_row = 1'b1;
                    if (abort) begin
                        state_d = IDLE;
                    end else if ((row_count + 1'b1) == rows_q) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else if (gap_q == '0) begin
                        state_d = ISSUE;
                    end else begin
                        gap_load = 1'b1;
                        state_d  = GAP;
                    end
                end else if (wd_expired) begin
                    state_d = IDLE;
                end else if (abort) begin
                    state_d = DRAIN;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_zero) begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                // The in-flight shift still completes a row, so it is counted.
                if (done_rise) begin
                    count_row = 1'b1;
                    state_d   = IDLE;
                end else if (wd_expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            frame_done <= 1'b0;
            row_count  <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= clkgen.shift_done;
            frame_done <= frame_done_d;
            if (accept) begin
                row_count <= '0;
            end else if (count_row) begin
                row_count <= row_count + 1'b1;
            end
        end
    end

    // Frame parameters are datapath values captured only when a frame is accepted.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            rows_q <= num_rows;
            gap_q  <= gap_cycles;
        end
    end

    // Loading gap-1 makes GAP last exactly gap_cycles cycles before ISSUE.
    seq_delay_counter #(.W(GAP_W)) u_gap_counter (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (gap_load),
        .dec      (state_q == GAP),
        .load_val (gap_q - 1'b1),
        .zero     (gap_zero)
    );

`ifdef SHIFT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic wd_active;
    logic wd_load;
    logic wd_zero;

    assign wd_active = (state_q == WAIT_DONE) || (state_q == DRAIN);
    assign wd_load   = ((state_d == WAIT_DONE) || (state_d == DRAIN)) && (state_d != state_q);

    seq_delay_counter #(.W(WD_W)) u_watchdog (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (wd_load),
        .dec      (wd_active),
        .load_val (WD_W'(TIMEOUT_CYCLES - 1)),
        .zero     (wd_zero)
    );

    assign wd_expired = wd_active & wd_zero;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (accept) begin
            timeout_err <= 1'b0;
        end else if (wd_expired && !done_rise) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign clkgen.shift_en = (state_q == ISSUE);
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_ccd_row_sequencer.sv
// Directed bench for ccd_row_sequencer with a behavioural clock-generator model and row/frame scoreboard.
module tb_ccd_row_sequencer;
    import ccd_seq_pkg::*;

    localparam int ROW_W = 12;
    localparam int GAP_W = 8;

    logic             clk_in = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [ROW_W-1:0] num_rows = '0;
    logic [GAP_W-1:0] gap_cycles = '0;
    logic             busy;
    logic             frame_done;
    logic             timeout_err;
    logic [ROW_W-1:0] row_count;

    logic model_en = 1'b1;
    logic model_done = 1'b0;
    logic manual_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fd_count = 0;
    int shift_cyc[$];
    logic [ROW_W-1:0] exp_row_q[$];
    logic [ROW_W-1:0] exp_fd_q[$];
    logic [ROW_W-1:0] prev_row = '0;
    logic [ROW_W-1:0] exp_v;
    logic             exp_ok;

    ccd_row_sequencer_if clk_if ();
    assign clk_if.shift_done = model_en ? model_done : manual_done;

    ccd_row_sequencer #(.ROW_W(ROW_W), .GAP_W(GAP_W)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .start       (start),
        .num_rows    (num_rows),
        .gap_cycles  (gap_cycles),
        .abort       (abort),
        .clkgen      (clk_if),
        .busy        (busy),
        .row_count   (row_count),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Clock generator: drops its flag when a shift starts, raises it CLK_GEN_CYCLES later.
    initial begin : clkgen_model
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk_in);
            if (clk_if.shift_en === 1'b1) begin
                model_done = 1'b0;
                cnt = CLK_GEN_CYCLES;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) model_done = 1'b1;
            end
        end
    end

    // Scoreboard: pop expected row counts on every increment and on every frame_done.
    always @(negedge clk_in) begin
        if (rst_n) begin
            if (clk_if.shift_en === 1'b1) shift_cyc.push_back(cyc);
            if (row_count !== prev_row && row_count !== '0) begin
                exp_ok = (exp_row_q.size() != 0);
                exp_v  = exp_ok ? exp_row_q.pop_front() : '1;
                checks++;
                assert (exp_ok && row_count === exp_v) else begin
                    failures++;
                    $error("FAIL row_step observed=%0d expected=%0d cyc=%0d", row_count, exp_v, cyc);
                end
            end
            if (frame_done === 1'b1) begin
                fd_count++;
                exp_ok = (exp_fd_q.size() != 0);
                exp_v  = exp_ok ? exp_fd_q.pop_front() : '1;
                checks++;
                assert (exp_ok && row_count === exp_v) else begin
                    failures++;
                    $error("FAIL frame_done_rows observed=%0d expected=%0d queued=%0d cyc=%0d",
                           row_count, exp_v, exp_ok, cyc);
                end
            end
        end
        prev_row = row_count;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int limit, output int at);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick(1);
            n++;
        end
        at = cyc;
        check({tag, "_idle_in_time"}, 32'(n < limit), 1);
    endtask

    task automatic wait_shifts(input string tag, input int target, input int limit);
        int n;
        n = 0;
        while (shift_cyc.size() < target && n < limit) begin
            tick(1);
            n++;
        end
        check({tag, "_shift_in_time"}, 32'(n < limit), 1);
    endtask

    task automatic begin_frame(input int rows, input int gap);
        num_rows   = ROW_W'(rows);
        gap_cycles = GAP_W'(gap);
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    initial begin
        int base;
        int t;
        int s1;
        int s2;
        int fd0;

        // Reset
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_shift_en", clk_if.shift_en, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_row_count", row_count, 0);
        rst_n = 1'b1;
        tick(2);

        // Basic 3-row frame, gap 4
        base = shift_cyc.size();
        exp_row_q.push_back(12'd1);
        exp_row_q.push_back(12'd2);
        exp_row_q.push_back(12'd3);
        exp_fd_q.push_back(12'd3);
        begin_frame(3, 4);
        check("basic_first_shift_en", clk_if.shift_en, 1);
        check("basic_busy", busy, 1);
        wait_idle("basic", 400, t);
        check("basic_frame_done", frame_done, 1);
        check("basic_shift_count", shift_cyc.size() - base, 3);
        check("basic_interval1", shift_cyc[base+1] - shift_cyc[base], CLK_GEN_CYCLES + 1 + 4);
        check("basic_interval2", shift_cyc[base+2] - shift_cyc[base+1], CLK_GEN_CYCLES + 1 + 4);
        check("basic_done_latency", t - shift_cyc[base+2], CLK_GEN_CYCLES + 1);
        check("basic_row_count", row_count, 3);
        tick(3);
        check("basic_row_hold", row_count, 3);

        // Zero rows
        base = shift_cyc.size();
        exp_fd_q.push_back(12'd3);
        begin_frame(0, 4);
        check("zero_frame_done", frame_done, 1);
        check("zero_busy", busy, 0);
        check("zero_shift_en", clk_if.shift_en, 0);
        tick(5);
        check("zero_no_shift", shift_cyc.size() - base, 0);
        check("zero_pulse_one_cycle", frame_done, 0);

        // Stale completion level
        manual_done = 1'b1;
        model_en    = 1'b0;
        tick(3);
        exp_row_q.push_back(12'd1);
        exp_fd_q.push_back(12'd1);
        begin_frame(1, 0);
        check("stale_shift_en", clk_if.shift_en, 1);
        tick(20);
        check("stale_not_counted", row_count, 0);
        check("stale_busy", busy, 1);
        manual_done = 1'b0;
        tick(2);
        manual_done = 1'b1;
        tick(1);
        check("stale_row_count", row_count, 1);
        check("stale_frame_done", frame_done, 1);
        check("stale_idle", busy, 0);
        tick(40);
        model_en = 1'b1;
        tick(3);

        // Abort 10 cycles after the 2nd shift of a 5-row frame
        base = shift_cyc.size();
        fd0  = fd_count;
        exp_row_q.push_back(12'd1);
        exp_row_q.push_back(12'd2);
        begin_frame(5, 2);
        wait_shifts("abort_shift", base + 2, 200);
        s2 = shift_cyc[base+1];
        check("abort_interval", s2 - shift_cyc[base], CLK_GEN_CYCLES + 1 + 2);
        while (cyc < s2 + 10) tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_drain_busy", busy, 1);
        wait_idle("abort", 200, t);
        check("abort_idle_cycle", t - s2, CLK_GEN_CYCLES + 1);
        check("abort_shift_count", shift_cyc.size() - base, 2);
        check("abort_row_count", row_count, 2);
        check("abort_no_frame_done", fd_count - fd0, 0);

        // Abort in GAP, with a start pulse while busy
        base = shift_cyc.size();
        fd0  = fd_count;
        exp_row_q.push_back(12'd1);
        begin_frame(4, 20);
        s1 = cyc;
        check("gap_shift_en", clk_if.shift_en, 1);
        tick(5);
        begin_frame(1, 0);
        num_rows = ROW_W'(4);
        while (cyc < s1 + CLK_GEN_CYCLES + 1) tick(1);
        check("gap_row_count", row_count, 1);
        check("gap_ignored_start_busy", busy, 1);
        check("gap_ignored_start_no_done", frame_done, 0);
        tick(6);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("gap_abort_idle", busy, 0);
        tick(30);
        check("gap_shift_count", shift_cyc.size() - base, 1);
        check("gap_no_frame_done", fd_count - fd0, 0);
        check("gap_row_hold", row_count, 1);

`ifdef SHIFT_TIMEOUT_EN
        // Generator never completes
        manual_done = 1'b0;
        model_en    = 1'b0;
        tick(2);
        fd0 = fd_count;
        begin_frame(2, 0);
        s1 = cyc;
        check("to_shift_en", clk_if.shift_en, 1);
        while (cyc < s1 + DEF_TIMEOUT_CYCLES) tick(1);
        check("to_before_limit", timeout_err, 0);
        check("to_before_busy", busy, 1);
        tick(1);
        check("to_err_set", timeout_err, 1);
        check("to_idle", busy, 0);
        tick(3);
        check("to_sticky", timeout_err, 1);
        check("to_no_frame_done", fd_count - fd0, 0);
        model_en = 1'b1;
        tick(3);
        exp_row_q.push_back(12'd1);
        exp_fd_q.push_back(12'd1);
        begin_frame(1, 0);
        check("to_cleared", timeout_err, 0);
        wait_idle("to_recover", 200, t);
        check("to_recover_done", frame_done, 1);
`else
        check("no_watchdog_err", timeout_err, 0);
`endif

        tick(2);
        check("sb_rows_drained", exp_row_q.size(), 0);
        check("sb_frames_drained", exp_fd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
